piso_serializer: RTL and testbench

- Parallel-in, serial-out shifter with a valid/ready load handshake. It is the transmit-side counterpart of the team's serial-to-parallel shift register.
- Accepts a WIDTH-bit word and emits it one bit per clock with a serial_valid qualifier and frame start/done markers.
- Supports back-to-back words with no idle gap.
- With MSB_FIRST=1 its serial stream feeds the LSB-shift-in SIPO directly, which reconstructs the original word after WIDTH clocks.

---
 rtl/piso_serializer.sv | 149 ++++++++++++++
 tb/tb_piso_serializer.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/piso_serializer.sv
// piso_serializer: parallel-in / serial-out shifter with a valid/ready load
// handshake. It emits one bit per clock with a valid qualifier and
// frame start/done markers. A new word can be accepted on the cycle that
// shows the last bit of the current word, so words stream with no gap.
module piso_serializer #(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_valid,
    input  logic [WIDTH-1:0] parallel_in,
    output logic             load_ready,
    output logic             serial_out,
    output logic             serial_valid,
    output logic             frame_start,
    output logic             frame_done,
    output logic             busy
);

    // Bit counter width; WIDTH >= 2 guarantees at least one bit.
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] shreg_reg, shreg_next;
    logic [CW-1:0]    cnt_reg, cnt_next;
    logic             serial_out_reg, serial_out_next;
    logic             serial_valid_reg, serial_valid_next;
    logic             frame_start_reg, frame_start_next;
    logic             frame_done_reg, frame_done_next;

    // shreg advanced by one position towards the transmit end, zero filled.
    logic [WIDTH-1:0] shreg_shifted;

    logic at_last;
    logic accept;

    // The bit that goes on the wire first for a given register content.
    function automatic logic head_bit(input logic [WIDTH-1:0] w);
        if (MSB_FIRST) begin
            return w[WIDTH-1];
        end else begin
            return w[0];
        end
    endfunction

    // Per-bit shift network: each position takes its neighbour on the
    // side away from the transmit end; the far end is filled with 0.
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_shift
            if (MSB_FIRST) begin : g_left
                if (gi == 0) begin : g_fill
                    assign shreg_shifted[gi] = 1'b0;
                end else begin : g_move
                    assign shreg_shifted[gi] = shreg_reg[gi-1];
                end
            end else begin : g_right
                if (gi == WIDTH - 1) begin : g_fill
                    assign shreg_shifted[gi] = 1'b0;
                end else begin : g_move
                    assign shreg_shifted[gi] = shreg_reg[gi+1];
                end
            end
        end
    endgenerate

    // Ready when idle or when the last bit of the current word is showing;
    // held low while reset is asserted so nothing can be taken then.
    assign at_last    = (state_reg == SHIFT) && (cnt_reg == CNT_LAST);
    assign load_ready = !reset && ((state_reg == IDLE) || at_last);
    assign accept     = load_valid && load_ready;

    assign serial_out   = serial_out_reg;
    assign serial_valid = serial_valid_reg;
    assign frame_start  = frame_start_reg;
    assign frame_done   = frame_done_reg;
    assign busy         = (state_reg == SHIFT);

    // State, data and output registers; reset clears everything at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg        <= IDLE;
            shreg_reg        <= '0;
            cnt_reg          <= '0;
            serial_out_reg   <= 1'b0;
            serial_valid_reg <= 1'b0;
            frame_start_reg  <= 1'b0;
            frame_done_reg   <= 1'b0;
        end else begin
            state_reg        <= state_next;
            shreg_reg        <= shreg_next;
            cnt_reg          <= cnt_next;
            serial_out_reg   <= serial_out_next;
            serial_valid_reg <= serial_valid_next;
            frame_start_reg  <= frame_start_next;
            frame_done_reg   <= frame_done_next;
        end
    end

    // Next-state logic: outputs are computed one cycle ahead so that the
    // registered serial_out/markers line up with the bit index in cnt.
    always_comb begin
        state_next        = state_reg;
        shreg_next        = shreg_reg;
        cnt_next          = cnt_reg;
        serial_out_next   = 1'b0;
        serial_valid_next = 1'b0;
        frame_start_next  = 1'b0;
        frame_done_next   = 1'b0;

        if (accept) begin
            // Fresh word (from IDLE or chained on the last bit).
            state_next        = SHIFT;
            shreg_next        = parallel_in;
            cnt_next          = '0;
            serial_out_next   = head_bit(parallel_in);
            serial_valid_next = 1'b1;
            frame_start_next  = 1'b1;
        end else begin
            case (state_reg)
                SHIFT: begin
                    if (cnt_reg != CNT_LAST) begin
                        shreg_next        = shreg_shifted;
                        cnt_next          = cnt_reg + CNT_ONE;
                        serial_out_next   = head_bit(shreg_shifted);
                        serial_valid_next = 1'b1;
                        frame_done_next   = ((cnt_reg + CNT_ONE) == CNT_LAST);
                    end else begin
                        // Last bit shown and nothing queued: go quiet.
                        state_next = IDLE;
                        shreg_next = '0;
                        cnt_next   = '0;
                    end
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_piso_serializer.sv
// tb_piso_serializer: drives one shared stimulus into an MSB-first and an
// LSB-first instance; a scoreboard queue holds the expected bit stream of
// every accepted word and is drained as serial bits appear.
module tb_piso_serializer;

    localparam int W = 4;

    logic         clk;
    logic         reset;
    logic         load_valid;
    logic [W-1:0] parallel_in;

    logic load_ready_m, serial_out_m, serial_valid_m, frame_start_m, frame_done_m, busy_m;
    logic load_ready_l, serial_out_l, serial_valid_l, frame_start_l, frame_done_l, busy_l;

    piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
        .clk          (clk),
        .reset        (reset),
        .load_valid   (load_valid),
        .parallel_in  (parallel_in),
        .load_ready   (load_ready_m),
        .serial_out   (serial_out_m),
        .serial_valid (serial_valid_m),
        .frame_start  (frame_start_m),
        .frame_done   (frame_done_m),
        .busy         (busy_m)
    );

    piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
        .clk          (clk),
        .reset        (reset),
        .load_valid   (load_valid),
        .parallel_in  (parallel_in),
        .load_ready   (load_ready_l),
        .serial_out   (serial_out_l),
        .serial_valid (serial_valid_l),
        .frame_start  (frame_start_l),
        .frame_done   (frame_done_l),
        .busy         (busy_l)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected per-bit entry: MSB-first bit, LSB-first bit, start, done.
    typedef struct packed {
        logic bm;
        logic bl;
        logic fs;
        logic fd;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   m_left   = 0;     // bits still to show, including the current one
    logic last_acc = 1'b0;  // the most recent edge accepted a word
    int   n_total  = 0;
    int   n_bad    = 0;
    logic [W-1:0] sipo;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h want=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Receiving SIPO model for the loopback check: LSB shift-in on valid bits.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) sipo <= '0;
        else if (serial_valid_m) sipo <= {sipo[W-2:0], serial_out_m};
    end

    // Handshake model: decides acceptance from its own ready and pushes bits.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            q.delete();
            m_left   = 0;
            last_acc = 1'b0;
        end else begin
            last_acc = load_valid && (m_left <= 1);
            if (m_left > 0) m_left--;
            if (last_acc) begin
                $display("accept word=%b", parallel_in);
                for (int i = 0; i < W; i++) begin
                    q.push_back('{bm: parallel_in[W-1-i], bl: parallel_in[i],
                                  fs: (i == 0), fd: (i == W-1)});
                end
                m_left = W;
            end
        end
    end

    // Output checker, sampled mid-cycle.
    always @(negedge clk) begin
        check_eq("ready_m", load_ready_m, !reset && (m_left <= 1));
        check_eq("ready_l", load_ready_l, !reset && (m_left <= 1));
        check_eq("busy_m", busy_m, m_left > 0);
        check_eq("busy_l", busy_l, m_left > 0);
        check_eq("valid_m", serial_valid_m, m_left > 0);
        check_eq("valid_l", serial_valid_l, m_left > 0);
        if (m_left > 0) begin
            if (q.size() == 0) begin
                check_eq("queue_underflow", 0, 1);
            end else begin
                e = q.pop_front();
                check_eq("bit_m", serial_out_m, e.bm);
                check_eq("bit_l", serial_out_l, e.bl);
                check_eq("start_m", frame_start_m, e.fs);
                check_eq("start_l", frame_start_l, e.fs);
                check_eq("done_m", frame_done_m, e.fd);
                check_eq("done_l", frame_done_l, e.fd);
            end
        end else begin
            check_eq("idle_bit_m", serial_out_m, 0);
            check_eq("idle_bit_l", serial_out_l, 0);
            check_eq("idle_marks_m", {frame_start_m, frame_done_m}, 0);
            check_eq("idle_marks_l", {frame_start_l, frame_done_l}, 0);
        end
    end

    task automatic idle(input int n);
        load_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Present a word and hold it until the model sees it accepted.
    task automatic send_word(input logic [W-1:0] d);
        logic got;
        got         = 1'b0;
        load_valid  = 1'b1;
        parallel_in = d;
        for (int k = 0; k < 20 && !got; k++) begin
            @(posedge clk);
            #1;
            got = last_acc;
        end
        if (!got) check_eq("accept_timeout", 0, 1);
        load_valid = 1'b0;
    endtask

    initial begin
        // Reset held with a word offered: nothing may be taken.
        reset       = 1'b1;
        load_valid  = 1'b1;
        parallel_in = 4'hF;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_ready", load_ready_m, 0);
        check_eq("rst_valid", serial_valid_m, 0);
        check_eq("rst_bit", serial_out_m, 0);
        reset      = 1'b0;
        load_valid = 1'b0;
        #1;
        check_eq("post_rst_ready", load_ready_m, 1);
        check_eq("post_rst_busy", busy_m, 0);
        idle(2);

        // Single word.
        send_word(4'b1010);
        idle(6);

        // Back-to-back words with valid held high.
        send_word(4'b1100);
        send_word(4'b0011);
        idle(6);

        // Word offered during bit 2 of an in-flight word waits for frame_done.
        send_word(4'b1001);
        idle(1);
        check_eq("busy_ready", load_ready_m, 0);
        send_word(4'b0110);
        idle(6);

        // Reset after two bits of a word: partial word dropped.
        send_word(4'b1011);
        idle(1);
        #2;
        reset = 1'b1;
        #1;
        check_eq("mid_rst_valid", serial_valid_m, 0);
        check_eq("mid_rst_bit", serial_out_m, 0);
        check_eq("mid_rst_done", frame_done_m, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        idle(1);
        send_word(4'b0101);
        idle(6);

        // Loopback into the SIPO model, then the LSB-first pattern.
        send_word(4'b1001);
        begin
            logic seen;
            seen = 1'b0;
            for (int k = 0; k < 20 && !seen; k++) begin
                @(negedge clk);
                seen = frame_done_m;
            end
            if (!seen) check_eq("done_timeout", 0, 1);
            @(posedge clk);
            #1;
            check_eq("sipo_loopback", sipo, 4'b1001);
        end
        idle(4);
        send_word(4'b0001);
        idle(6);

        check_eq("queue_drained", q.size(), 0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    // Global bound on run time.
    initial begin
        #100000;
        n_bad++;
        $display("FAIL watchdog expired");
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
